reorder_buffer_mwb: RTL and testbench
=====================================

Name: reorder_buffer_mwb

Overview:
- Parametrised successor of the single-commit reorder buffer.
- Circular in-order queue of ROB_SIZE entries, filled by instruction fetch and completed by WB_PORTS generic write-back channels (ALUs, LSB loads).
- Commits one entry per cycle to the RF, LSB and branch predictor.
- New behaviour: JALR target-misprediction recovery, same-cycle write-back bypass on operand lookup, and an occupancy count output.

Parameters:
ROB_WIDTH, 4, log2 of entry count; ROB_SIZE = 2**ROB_WIDTH
WB_PORTS, 3, number of write-back channels (1..8)
LOCAL_WIDTH, 6, predictor index width carried in branch entries

Ports:
clk_in  in  1  system clock
rst_n_in  in  1  asynchronous active-low reset
rdy_in  in  1  global stall when low
issue_signal  in  1  issue new entry this cycle
issue_opcode  in  2  REG/STORE/BRANCH/JALR
issue_value_ready  in  1  entry already complete at issue
issue_value  in  32  initial value (JALR: PC+4; BRANCH: encoded word)
issue_rd_id  in  5  destination register
issue_pc_prediction  in  32  predicted JALR target
wb_done  in  WB_PORTS  per-channel valid
wb_value  in  32*WB_PORTS  channel k at [32k+31:32k]
wb_tag  in  ROB_WIDTH*WB_PORTS  channel k at [ROB_WIDTH*k+ROB_WIDTH-1:ROB_WIDTH*k]
rob_tag_rs1, rob_tag_rs2  in  ROB_WIDTH  operand lookup tags
rob_tag  out  ROB_WIDTH  tag allocated to next issue (= rear)
rob_value_rs1, rob_value_rs2  out  32  operand values
rob_ready_rs1, rob_ready_rs2  out  1  operand valid
count  out  ROB_WIDTH+1  occupied entries
full  out  1  fetch must not issue
reg_done, reg_value[32], reg_id[5], reg_tag[ROB_WIDTH]  out  RF commit
lsb_done, lsb_tag[ROB_WIDTH]  out  store commit
predictor_signal, predictor_branch, predictor_addr[LOCAL_WIDTH]  out  branch update
clear_signal  out  1  misprediction flush pulse
correct_pc  out  32  restart PC

Behaviour:
- Reset (async, rst_n_in low):
  - All entries non-busy and non-ready; front = rear = count = 0.
  - All registered outputs are 0.
- rdy_in low: all state and registered outputs hold.
- Entry state: busy, ready, opcode, rd_id, value[32], target[32] (JALR only).
- Issue (issue_signal & ~clear_signal):
  - Entry rear is written with busy=1, ready=issue_value_ready, value=issue_value, target=issue_pc_prediction.
  - rear wraps modulo ROB_SIZE.
  - Issue while count==ROB_SIZE is ignored.
- full = (count==ROB_SIZE) | (count==ROB_SIZE-1 & issue_signal). This is combinational.
- Write-back, channel k with wb_done[k]:
  - Ignored if the entry is not busy, is already ready, or clear_signal is high.
  - Sets ready=1.
  - REG/STORE: value <= wb_value.
  - BRANCH: value[0] <= wb_value[0] only.
  - JALR: target <= wb_value; value (PC+4) is untouched.
  - Two channels hitting the same tag in one cycle: lowest index wins.
  - Write-back and issue to the same tag in one cycle: issue wins.
- Operand lookup (combinational):
  - rob_ready_rsX = busy & (ready | any wb_done[k] with wb_tag[k]==tag).
  - rob_value_rsX = matching wb_value (lowest k) if bypassing, else stored value.
  - A bypass on a BRANCH entry is not reported ready.
- Commit, when front is busy & ready & ~clear_signal: one entry per cycle; entry freed; front++. Outputs are registered one-cycle pulses:
  - REG: reg_done=1, reg_value=value, reg_id, reg_tag=front.
  - STORE: lsb_done=1, lsb_tag=front.
  - BRANCH:
    - predictor_signal=1, predictor_branch=value[0], predictor_addr=value[31:32-LOCAL_WIDTH].
    - If value[1]^value[0]: clear_signal=1, correct_pc=value & 32'h03FFFFFC.
  - JALR:
    - reg_done with reg_value=value (PC+4).
    - If target != stored prediction: clear_signal=1, correct_pc=target & ~3. The prediction is held in a separate pred field, so total per-entry state is value, target, pred.
  - No commit that cycle: all done/clear pulses return to 0.
- Flush:
  - On the first rdy cycle with clear_signal=1, all entries are invalidated, front=rear=count=0, and clear_signal returns to 0.
  - Issue and write-back are ignored in that cycle.
- count: +1 on accepted issue, -1 on commit, unchanged when both occur; range 0..ROB_SIZE.

Decomposition:
- Package rob_pkg:
  - Opcode constants REG_INSTR=0, STORE_INSTR=1, BRANCH_INSTR=2, JALR_INSTR=3.
  - Branch-word field positions (pred bit 1, result bit 0, index MSBs).
- Sub-module rob_wb_select (parametrised by WB_PORTS, ROB_WIDTH):
  - Priority match of a tag against all channels; returns hit and value.
  - Instantiated per entry-update path and per operand lookup.

Test Plan:
- Reset, then issue 16 REG entries with value_ready=0 → full asserts when issuing the 16th; count=16; no commit.
- Issue REG tag0; same cycle wb_done[1] on tag0 with 0x55 → write-back ignored; next cycle wb 0x55 → reg_done pulse with reg_value=0x55, reg_tag=0.
- Two channels write tag2 with 0xA and 0xB in the same cycle → committed value 0xA.
- BRANCH issued with value bit1=1, resolves bit0=0 → clear_signal pulse and correct_pc=value&0x03FFFFFC; next cycle count=0 and later wb ignored.
- JALR issued with PC+4=0x104, prediction 0x200; wb target 0x300 → reg_value=0x104, clear_signal=1, correct_pc=0x300. Repeat with target 0x200 → no clear.
- Lookup of rs1 tag3 while wb on tag3 with 0x77 in the same cycle → rob_ready_rs1=1, rob_value_rs1=0x77. Assert rst_n_in mid-commit → outputs 0 immediately.

Source files
------------

// File: rtl/rob_pkg.sv
// rtl/rob_pkg.sv - shared opcodes and branch-word layout for the reorder buffer
package rob_pkg;

  // Entry opcodes as presented by fetch
  localparam logic [1:0] REG_INSTR    = 2'd0;
  localparam logic [1:0] STORE_INSTR  = 2'd1;
  localparam logic [1:0] BRANCH_INSTR = 2'd2;
  localparam logic [1:0] JALR_INSTR   = 2'd3;

  // Branch word: bit 1 = predicted taken, bit 0 = resolved taken,
  // top bits = predictor table index
  localparam int BR_PRED_BIT   = 1;
  localparam int BR_RESULT_BIT = 0;
  localparam int BR_INDEX_MSB  = 31;

  // Restart-PC masks for branch and JALR recovery
  localparam logic [31:0] BR_PC_MASK   = 32'h03FF_FFFC;
  localparam logic [31:0] JALR_PC_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/rob_wb_select.sv
// rtl/rob_wb_select.sv - priority match of one tag against all write-back channels
module rob_wb_select #(
  parameter int WB_PORTS  = 3,
  parameter int ROB_WIDTH = 4
) (
  input  logic [ROB_WIDTH-1:0]          tag_i,
  input  logic [WB_PORTS-1:0]           wb_done_i,
  input  logic [32*WB_PORTS-1:0]        wb_value_i,
  input  logic [ROB_WIDTH*WB_PORTS-1:0] wb_tag_i,
  output logic                          hit_o,
  output logic [31:0]                   value_o
);

  // Scan from the highest channel down so the lowest matching index wins
  always_comb begin
    hit_o   = 1'b0;
    value_o = '0;
    for (int k = WB_PORTS - 1; k >= 0; k--) begin
      if (wb_done_i[k] && (wb_tag_i[ROB_WIDTH*k +: ROB_WIDTH] == tag_i)) begin
        hit_o   = 1'b1;
        value_o = wb_value_i[32*k +: 32];
      end
    end
  end

endmodule

// File: rtl/reorder_buffer_mwb.sv
// rtl/reorder_buffer_mwb.sv - in-order reorder buffer with multiple write-back channels
module reorder_buffer_mwb
  import rob_pkg::*;
#(
  parameter int ROB_WIDTH   = 4,
  parameter int WB_PORTS    = 3,
  parameter int LOCAL_WIDTH = 6
) (
  input  logic                          clk_in,
  input  logic                          rst_n_in,
  input  logic                          rdy_in,
  input  logic                          issue_signal,
  input  logic [1:0]                    issue_opcode,
  input  logic                          issue_value_ready,
  input  logic [31:0]                   issue_value,
  input  logic [4:0]                    issue_rd_id,
  input  logic [31:0]                   issue_pc_prediction,
  input  logic [WB_PORTS-1:0]           wb_done,
  input  logic [32*WB_PORTS-1:0]        wb_value,
  input  logic [ROB_WIDTH*WB_PORTS-1:0] wb_tag,
  input  logic [ROB_WIDTH-1:0]          rob_tag_rs1,
  input  logic [ROB_WIDTH-1:0]          rob_tag_rs2,
  output logic [ROB_WIDTH-1:0]          rob_tag,
  output logic [31:0]                   rob_value_rs1,
  output logic [31:0]                   rob_value_rs2,
  output logic                          rob_ready_rs1,
  output logic                          rob_ready_rs2,
  output logic [ROB_WIDTH:0]            count,
  output logic                          full,
  output logic                          reg_done,
  output logic [31:0]                   reg_value,
  output logic [4:0]                    reg_id,
  output logic [ROB_WIDTH-1:0]          reg_tag,
  output logic                          lsb_done,
  output logic [ROB_WIDTH-1:0]          lsb_tag,
  output logic                          predictor_signal,
  output logic                          predictor_branch,
  output logic [LOCAL_WIDTH-1:0]        predictor_addr,
  output logic                          clear_signal,
  output logic [31:0]                   correct_pc
);

  localparam int ROB_SIZE = 2 ** ROB_WIDTH;
  localparam logic [ROB_WIDTH:0] SIZE_CNT = (ROB_WIDTH + 1)'(ROB_SIZE);

  // Entry storage; pred keeps the fetch-time JALR guess while target takes the resolved one
  logic [ROB_SIZE-1:0] busy_q, ready_q;
  logic [1:0]          opcode_q [ROB_SIZE];
  logic [4:0]          rd_q     [ROB_SIZE];
  logic [31:0]         value_q  [ROB_SIZE];
  logic [31:0]         target_q [ROB_SIZE];
  logic [31:0]         pred_q   [ROB_SIZE];

  logic [ROB_WIDTH-1:0] front_q, front_d, rear_q, rear_d;
  logic [ROB_WIDTH:0]   count_q, count_d;

  logic                   reg_done_q, lsb_done_q, pred_signal_q, pred_branch_q, clear_q;
  logic [31:0]            reg_value_q, correct_pc_q;
  logic [4:0]             reg_id_q;
  logic [ROB_WIDTH-1:0]   reg_tag_q, lsb_tag_q;
  logic [LOCAL_WIDTH-1:0] pred_addr_q;

  logic                issue_ok, commit_ok;
  logic [ROB_SIZE-1:0] ent_hit;
  logic [31:0]         ent_val [ROB_SIZE];
  logic                rs1_hit, rs2_hit;
  logic [31:0]         rs1_val, rs2_val;

  // One write-back selector per entry drives that entry's update path
  for (genvar i = 0; i < ROB_SIZE; i++) begin : g_ent_sel
    rob_wb_select #(.WB_PORTS(WB_PORTS), .ROB_WIDTH(ROB_WIDTH)) u_sel (
      .tag_i(ROB_WIDTH'(i)), .wb_done_i(wb_done), .wb_value_i(wb_value),
      .wb_tag_i(wb_tag), .hit_o(ent_hit[i]), .value_o(ent_val[i])
    );
  end

  rob_wb_select #(.WB_PORTS(WB_PORTS), .ROB_WIDTH(ROB_WIDTH)) u_rs1_sel (
    .tag_i(rob_tag_rs1), .wb_done_i(wb_done), .wb_value_i(wb_value),
    .wb_tag_i(wb_tag), .hit_o(rs1_hit), .value_o(rs1_val)
  );

  rob_wb_select #(.WB_PORTS(WB_PORTS), .ROB_WIDTH(ROB_WIDTH)) u_rs2_sel (
    .tag_i(rob_tag_rs2), .wb_done_i(wb_done), .wb_value_i(wb_value),
    .wb_tag_i(wb_tag), .hit_o(rs2_hit), .value_o(rs2_val)
  );

  // A pending flush blocks issue and commit; a full queue drops issue
  assign issue_ok  = issue_signal & ~clear_q & (count_q != SIZE_CNT);
  assign commit_ok = busy_q[front_q] & ready_q[front_q] & ~clear_q;

  // Pointer and occupancy next-state
  always_comb begin
    front_d = front_q;
    rear_d  = rear_q;
    count_d = count_q;
    if (clear_q) begin
      front_d = '0;
      rear_d  = '0;
      count_d = '0;
    end else begin
      if (issue_ok)  rear_d  = rear_q + ROB_WIDTH'(1);
      if (commit_ok) front_d = front_q + ROB_WIDTH'(1);
      case ({issue_ok, commit_ok})
        2'b10:   count_d = count_q + (ROB_WIDTH + 1)'(1);
        2'b01:   count_d = count_q - (ROB_WIDTH + 1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Queue pointers
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      front_q <= '0;
      rear_q  <= '0;
      count_q <= '0;
    end else if (rdy_in) begin
      front_q <= front_d;
      rear_q  <= rear_d;
      count_q <= count_d;
    end
  end

  // Entry updates: issue beats write-back on the same slot; commit frees the head
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      busy_q  <= '0;
      ready_q <= '0;
      for (int i = 0; i < ROB_SIZE; i++) begin
        opcode_q[i] <= '0;
        rd_q[i]     <= '0;
        value_q[i]  <= '0;
        target_q[i] <= '0;
        pred_q[i]   <= '0;
      end
    end else if (rdy_in) begin
      if (clear_q) begin
        busy_q  <= '0;
        ready_q <= '0;
      end else begin
        for (int i = 0; i < ROB_SIZE; i++) begin
          if (issue_ok && (rear_q == ROB_WIDTH'(i))) begin
            busy_q[i]   <= 1'b1;
            ready_q[i]  <= issue_value_ready;
            opcode_q[i] <= issue_opcode;
            rd_q[i]     <= issue_rd_id;
            value_q[i]  <= issue_value;
            target_q[i] <= issue_pc_prediction;
            pred_q[i]   <= issue_pc_prediction;
          end else if (busy_q[i] && !ready_q[i] && ent_hit[i]) begin
            ready_q[i] <= 1'b1;
            case (opcode_q[i])
              BRANCH_INSTR: value_q[i][BR_RESULT_BIT] <= ent_val[i][BR_RESULT_BIT];
              JALR_INSTR:   target_q[i] <= ent_val[i];
              default:      value_q[i] <= ent_val[i];
            endcase
          end
        end
        if (commit_ok) begin
          busy_q[front_q]  <= 1'b0;
          ready_q[front_q] <= 1'b0;
        end
      end
    end
  end

  // Commit outputs: pulses drop every active cycle, data fields hold until next commit
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      reg_done_q    <= 1'b0;
      reg_value_q   <= '0;
      reg_id_q      <= '0;
      reg_tag_q     <= '0;
      lsb_done_q    <= 1'b0;
      lsb_tag_q     <= '0;
      pred_signal_q <= 1'b0;
      pred_branch_q <= 1'b0;
      pred_addr_q   <= '0;
      clear_q       <= 1'b0;
      correct_pc_q  <= '0;
    end else if (rdy_in) begin
      reg_done_q    <= 1'b0;
      lsb_done_q    <= 1'b0;
      pred_signal_q <= 1'b0;
      clear_q       <= 1'b0;
      if (commit_ok) begin
        case (opcode_q[front_q])
          REG_INSTR: begin
            reg_done_q  <= 1'b1;
            reg_value_q <= value_q[front_q];
            reg_id_q    <= rd_q[front_q];
            reg_tag_q   <= front_q;
          end
          STORE_INSTR: begin
            lsb_done_q <= 1'b1;
            lsb_tag_q  <= front_q;
          end
          BRANCH_INSTR: begin
            pred_signal_q <= 1'b1;
            pred_branch_q <= value_q[front_q][BR_RESULT_BIT];
            pred_addr_q   <= value_q[front_q][BR_INDEX_MSB -: LOCAL_WIDTH];
            if (value_q[front_q][BR_PRED_BIT] != value_q[front_q][BR_RESULT_BIT]) begin
              clear_q      <= 1'b1;
              correct_pc_q <= value_q[front_q] & BR_PC_MASK;
            end
          end
          default: begin
            reg_done_q  <= 1'b1;
            reg_value_q <= value_q[front_q];
            reg_id_q    <= rd_q[front_q];
            reg_tag_q   <= front_q;
            if (target_q[front_q] != pred_q[front_q]) begin
              clear_q      <= 1'b1;
              correct_pc_q <= target_q[front_q] & JALR_PC_MASK;
            end
          end
        endcase
      end
    end
  end

  // Operand lookup with same-cycle bypass; a bypassed branch result is never an operand
  assign rob_ready_rs1 = busy_q[rob_tag_rs1] &
                         (ready_q[rob_tag_rs1] | (rs1_hit & (opcode_q[rob_tag_rs1] != BRANCH_INSTR)));
  assign rob_ready_rs2 = busy_q[rob_tag_rs2] &
                         (ready_q[rob_tag_rs2] | (rs2_hit & (opcode_q[rob_tag_rs2] != BRANCH_INSTR)));
  assign rob_value_rs1 = rs1_hit ? rs1_val : value_q[rob_tag_rs1];
  assign rob_value_rs2 = rs2_hit ? rs2_val : value_q[rob_tag_rs2];

  assign rob_tag          = rear_q;
  assign count            = count_q;
  assign full             = (count_q == SIZE_CNT) |
                            ((count_q == SIZE_CNT - (ROB_WIDTH + 1)'(1)) & issue_signal);
  assign reg_done         = reg_done_q;
  assign reg_value        = reg_value_q;
  assign reg_id           = reg_id_q;
  assign reg_tag          = reg_tag_q;
  assign lsb_done         = lsb_done_q;
  assign lsb_tag          = lsb_tag_q;
  assign predictor_signal = pred_signal_q;
  assign predictor_branch = pred_branch_q;
  assign predictor_addr   = pred_addr_q;
  assign clear_signal     = clear_q;
  assign correct_pc       = correct_pc_q;

endmodule

// File: tb/tb_reorder_buffer_mwb.sv
// tb/tb_reorder_buffer_mwb.sv - directed and random checks of reorder_buffer_mwb against a queue model
module tb_reorder_buffer_mwb;

  localparam int RW   = 4;
  localparam int WB   = 3;
  localparam int LW   = 6;
  localparam int SIZE = 16;
  localparam logic [1:0] OP_REG = 2'd0, OP_ST = 2'd1, OP_BR = 2'd2, OP_JALR = 2'd3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n, rdy, issue_signal, issue_value_ready;
  logic [1:0]       issue_opcode;
  logic [31:0]      issue_value, issue_pc_prediction;
  logic [4:0]       issue_rd_id;
  logic [WB-1:0]    wb_done;
  logic [32*WB-1:0] wb_value;
  logic [RW*WB-1:0] wb_tag;
  logic [RW-1:0]    rob_tag_rs1, rob_tag_rs2;

  logic [RW-1:0] rob_tag, reg_tag, lsb_tag;
  logic [31:0]   rob_value_rs1, rob_value_rs2, reg_value, correct_pc;
  logic          rob_ready_rs1, rob_ready_rs2, full, reg_done, lsb_done;
  logic          predictor_signal, predictor_branch, clear_signal;
  logic [RW:0]   count;
  logic [4:0]    reg_id;
  logic [LW-1:0] predictor_addr;

  reorder_buffer_mwb #(.ROB_WIDTH(RW), .WB_PORTS(WB), .LOCAL_WIDTH(LW)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .rdy_in(rdy),
    .issue_signal(issue_signal), .issue_opcode(issue_opcode),
    .issue_value_ready(issue_value_ready), .issue_value(issue_value),
    .issue_rd_id(issue_rd_id), .issue_pc_prediction(issue_pc_prediction),
    .wb_done(wb_done), .wb_value(wb_value), .wb_tag(wb_tag),
    .rob_tag_rs1(rob_tag_rs1), .rob_tag_rs2(rob_tag_rs2),
    .rob_tag(rob_tag), .rob_value_rs1(rob_value_rs1), .rob_value_rs2(rob_value_rs2),
    .rob_ready_rs1(rob_ready_rs1), .rob_ready_rs2(rob_ready_rs2),
    .count(count), .full(full),
    .reg_done(reg_done), .reg_value(reg_value), .reg_id(reg_id), .reg_tag(reg_tag),
    .lsb_done(lsb_done), .lsb_tag(lsb_tag),
    .predictor_signal(predictor_signal), .predictor_branch(predictor_branch),
    .predictor_addr(predictor_addr),
    .clear_signal(clear_signal), .correct_pc(correct_pc)
  );

  typedef struct {
    logic [1:0]  op;
    bit          rdy;
    logic [31:0] val;
    logic [31:0] tgt;
    logic [31:0] pred;
    logic [4:0]  rd;
  } ent_t;

  ent_t        q[$];
  int          m_front;
  bit          e_reg_done, e_lsb_done, e_ps, e_pb, e_clear;
  logic [31:0] e_reg_value, e_cpc;
  logic [4:0]  e_reg_id;
  int          e_reg_tag, e_lsb_tag;
  logic [5:0]  e_pa;
  int          n_checks, n_errors;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_front = 0;
    e_reg_done = 0; e_lsb_done = 0; e_ps = 0; e_pb = 0; e_clear = 0;
    e_reg_value = 0; e_cpc = 0; e_reg_id = 0; e_reg_tag = 0; e_lsb_tag = 0; e_pa = 0;
  endtask

  task automatic idle_inputs();
    issue_signal = 0; issue_opcode = 0; issue_value_ready = 0; issue_value = 0;
    issue_rd_id = 0; issue_pc_prediction = 0;
    wb_done = '0; wb_value = '0; wb_tag = '0;
    rob_tag_rs1 = 0; rob_tag_rs2 = 0;
  endtask

  task automatic set_issue(input logic [1:0] op, input bit vr, input logic [31:0] v,
                           input logic [4:0] rd, input logic [31:0] pred);
    issue_signal = 1; issue_opcode = op; issue_value_ready = vr;
    issue_value = v; issue_rd_id = rd; issue_pc_prediction = pred;
  endtask

  task automatic set_wb(input int k, input int t, input logic [31:0] v);
    wb_done[k] = 1'b1;
    wb_tag[RW*k +: RW] = RW'(t);
    wb_value[32*k +: 32] = v;
  endtask

  // Lowest-numbered active channel carrying tag t
  function automatic bit wb_hit(input int t, output logic [31:0] v);
    v = 0;
    for (int k = 0; k < WB; k++) begin
      if (wb_done[k] && wb_tag[RW*k +: RW] == RW'(t)) begin
        v = wb_value[32*k +: 32];
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  task automatic lookup(input int t, output bit r, output logic [31:0] v);
    int j;
    bit h;
    logic [31:0] wv;
    r = 0; v = 0;
    j = (t - m_front + SIZE) % SIZE;
    if (j < q.size()) begin
      h = wb_hit(t, wv);
      r = q[j].rdy || (h && q[j].op != OP_BR);
      v = h ? wv : q[j].val;
    end
  endtask

  task automatic check_outputs();
    int n;
    bit r;
    logic [31:0] v;
    n = q.size();
    chk("count", count, n);
    chk("full", full, (n == SIZE) || (n == SIZE - 1 && issue_signal));
    chk("rob_tag", rob_tag, (m_front + n) % SIZE);
    chk("reg_done", reg_done, e_reg_done);
    if (e_reg_done) begin
      chk("reg_value", reg_value, e_reg_value);
      chk("reg_id", reg_id, e_reg_id);
      chk("reg_tag", reg_tag, e_reg_tag);
    end
    chk("lsb_done", lsb_done, e_lsb_done);
    if (e_lsb_done) chk("lsb_tag", lsb_tag, e_lsb_tag);
    chk("pred_signal", predictor_signal, e_ps);
    if (e_ps) begin
      chk("pred_branch", predictor_branch, e_pb);
      chk("pred_addr", predictor_addr, e_pa);
    end
    chk("clear", clear_signal, e_clear);
    if (e_clear) chk("correct_pc", correct_pc, e_cpc);
    lookup(rob_tag_rs1, r, v);
    chk("rs1_ready", rob_ready_rs1, r);
    if (r) chk("rs1_value", rob_value_rs1, v);
    lookup(rob_tag_rs2, r, v);
    chk("rs2_ready", rob_ready_rs2, r);
    if (r) chk("rs2_value", rob_value_rs2, v);
  endtask

  task automatic model_step();
    int pre;
    bit commit;
    ent_t h, e;
    logic [31:0] wv;
    if (!rdy) return;
    if (e_clear) begin
      q.delete();
      m_front = 0;
      e_reg_done = 0; e_lsb_done = 0; e_ps = 0; e_clear = 0;
      return;
    end
    e_reg_done = 0; e_lsb_done = 0; e_ps = 0;
    pre = q.size();
    commit = (pre > 0) && q[0].rdy;
    if (commit) begin
      h = q[0];
      case (h.op)
        OP_REG: begin
          e_reg_done = 1; e_reg_value = h.val; e_reg_id = h.rd; e_reg_tag = m_front;
        end
        OP_ST: begin
          e_lsb_done = 1; e_lsb_tag = m_front;
        end
        OP_BR: begin
          e_ps = 1; e_pb = h.val[0]; e_pa = h.val[31:26];
          if (h.val[1] != h.val[0]) begin
            e_clear = 1; e_cpc = h.val & 32'h03FF_FFFC;
          end
        end
        default: begin
          e_reg_done = 1; e_reg_value = h.val; e_reg_id = h.rd; e_reg_tag = m_front;
          if (h.tgt != h.pred) begin
            e_clear = 1; e_cpc = h.tgt & 32'hFFFF_FFFC;
          end
        end
      endcase
    end
    for (int j = 0; j < pre; j++) begin
      if (!q[j].rdy && wb_hit((m_front + j) % SIZE, wv)) begin
        e = q[j];
        e.rdy = 1;
        case (e.op)
          OP_BR:   e.val[0] = wv[0];
          OP_JALR: e.tgt = wv;
          default: e.val = wv;
        endcase
        q[j] = e;
      end
    end
    if (commit) begin
      void'(q.pop_front());
      m_front = (m_front + 1) % SIZE;
    end
    if (issue_signal && pre < SIZE) begin
      e.op = issue_opcode; e.rdy = issue_value_ready; e.val = issue_value;
      e.tgt = issue_pc_prediction; e.pred = issue_pc_prediction; e.rd = issue_rd_id;
      q.push_back(e);
    end
  endtask

  task automatic step_cycle();
    @(negedge clk);
    check_outputs();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 0;
    idle_inputs();
    rdy = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  task automatic rand_inputs(input bit fill);
    idle_inputs();
    rdy = ($urandom_range(0, 9) != 0);
    issue_signal = fill ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 2) == 0);
    issue_opcode = 2'($urandom_range(0, 3));
    issue_value_ready = ($urandom_range(0, 3) == 0);
    issue_value = $urandom;
    issue_rd_id = 5'($urandom_range(0, 31));
    issue_pc_prediction = ($urandom_range(0, 1) == 1) ? 32'h0000_2000 : $urandom;
    for (int k = 0; k < WB; k++) begin
      if ($urandom_range(0, fill ? 5 : 1) == 0)
        set_wb(k, (m_front + int'($urandom_range(0, 5))) % SIZE,
               ($urandom_range(0, 1) == 1) ? 32'h0000_2000 : $urandom);
    end
    rob_tag_rs1 = RW'($urandom_range(0, SIZE - 1));
    rob_tag_rs2 = ($urandom_range(0, 1) == 1) ? wb_tag[RW-1:0] : RW'($urandom_range(0, SIZE - 1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] seen;
    bit found;
    n_checks = 0;
    n_errors = 0;

    // Reset state
    do_reset();
    chk("rst_count", count, 0);
    chk("rst_rob_tag", rob_tag, 0);
    chk("rst_reg_done", reg_done, 0);
    chk("rst_reg_value", reg_value, 0);
    chk("rst_clear", clear_signal, 0);
    chk("rst_correct_pc", correct_pc, 0);

    // Fill all 16 slots with incomplete REG entries
    for (int i = 0; i < SIZE; i++) begin
      idle_inputs();
      set_issue(OP_REG, 0, 32'(i * 3), 5'(i), 0);
      if (i == SIZE - 1) begin
        #1;
        chk("full_on_last_issue", full, 1);
      end
      step_cycle();
    end
    idle_inputs();
    chk("count_full", count, SIZE);
    set_issue(OP_REG, 1, 32'h1234, 5'd3, 0);
    step_cycle();
    idle_inputs();
    step_cycle();
    chk("no_commit_when_full", reg_done, 0);

    // Write-back colliding with issue is dropped
    do_reset();
    set_issue(OP_REG, 0, 32'h0, 5'd7, 0);
    set_wb(1, 0, 32'h55);
    step_cycle();
    idle_inputs();
    set_wb(0, 0, 32'h55);
    step_cycle();
    idle_inputs();
    step_cycle();
    chk("t_wb_reg_done", reg_done, 1);
    chk("t_wb_reg_value", reg_value, 32'h55);
    chk("t_wb_reg_tag", reg_tag, 0);

    // Two channels on one tag: lowest index wins
    do_reset();
    set_issue(OP_REG, 1, 32'h1, 5'd1, 0); step_cycle();
    idle_inputs(); set_issue(OP_REG, 1, 32'h2, 5'd2, 0); step_cycle();
    idle_inputs(); set_issue(OP_REG, 0, 32'h3, 5'd3, 0); step_cycle();
    idle_inputs(); set_wb(1, 2, 32'hA); set_wb(2, 2, 32'hB); step_cycle();
    idle_inputs();
    found = 0;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      step_cycle();
      if (reg_done && reg_tag == 2 && !found) begin
        found = 1;
        seen = reg_value;
      end
    end
    chk("t_prio_found", found, 1);
    chk("t_prio_value", seen, 32'hA);

    // Branch mispredict flush
    do_reset();
    set_issue(OP_BR, 0, 32'hABCD_1232, 5'd0, 0); step_cycle();
    idle_inputs(); set_issue(OP_REG, 0, 32'h9, 5'd4, 0); set_wb(0, 0, 32'h0); step_cycle();
    idle_inputs(); step_cycle();
    chk("t_br_clear", clear_signal, 1);
    chk("t_br_pc", correct_pc, 32'h03CD_1230);
    chk("t_br_branch", predictor_branch, 0);
    chk("t_br_addr", predictor_addr, 6'h2A);
    step_cycle();
    chk("t_br_count", count, 0);
    chk("t_br_clear_drop", clear_signal, 0);
    set_wb(0, 1, 32'h99); step_cycle();
    idle_inputs(); step_cycle();
    chk("t_br_wb_ignored", reg_done, 0);

    // JALR target mispredict, then a correctly predicted one
    do_reset();
    set_issue(OP_JALR, 0, 32'h104, 5'd1, 32'h200); step_cycle();
    idle_inputs(); set_wb(0, 0, 32'h300); step_cycle();
    idle_inputs(); step_cycle();
    chk("t_jalr_done", reg_done, 1);
    chk("t_jalr_value", reg_value, 32'h104);
    chk("t_jalr_clear", clear_signal, 1);
    chk("t_jalr_pc", correct_pc, 32'h300);
    step_cycle();
    set_issue(OP_JALR, 0, 32'h104, 5'd1, 32'h200); step_cycle();
    idle_inputs(); set_wb(2, 0, 32'h200); step_cycle();
    idle_inputs(); step_cycle();
    chk("t_jalr2_done", reg_done, 1);
    chk("t_jalr2_value", reg_value, 32'h104);
    chk("t_jalr2_no_clear", clear_signal, 0);

    // Same-cycle bypass on lookup, then asynchronous reset mid-commit
    do_reset();
    for (int i = 0; i < 4; i++) begin
      idle_inputs();
      set_issue(OP_REG, 0, 32'(32'h10 + i), 5'(i + 1), 0);
      step_cycle();
    end
    idle_inputs();
    rob_tag_rs1 = 3;
    rob_tag_rs2 = 2;
    set_wb(2, 3, 32'h77);
    #1;
    chk("t_byp_ready", rob_ready_rs1, 1);
    chk("t_byp_value", rob_value_rs1, 32'h77);
    chk("t_byp_rs2_notready", rob_ready_rs2, 0);
    step_cycle();
    idle_inputs();
    set_wb(0, 0, 32'h1); set_wb(1, 1, 32'h2); set_wb(2, 2, 32'h3);
    step_cycle();
    idle_inputs();
    step_cycle();
    chk("t_rst_pre_done", reg_done, 1);
    rst_n = 0;
    #1;
    chk("t_rst_async_done", reg_done, 0);
    chk("t_rst_async_value", reg_value, 0);
    chk("t_rst_async_count", count, 0);
    chk("t_rst_async_tag", rob_tag, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1;

    // Random traffic against the queue model
    for (int c = 0; c < 3000; c++) begin
      rand_inputs((c % 400) < 200);
      step_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
